// File: rtl/ili9341_spi_controller.sv
// ili9341_spi_controller
//   Brings up an ILI9341 TFT through a byte-level SPI master and then streams
//   RGB565 frames from a byte-addressed framebuffer, forever.
//   Sequence: RESX pulse, SWRESET, SLPOUT, MADCTL, COLMOD, DISPON, RDDST
//   (dummy + 4 status bytes), CASET, PASET, RAMWR, then pixel bytes. After
//   the last byte of a frame it re-issues RAMWR and restarts at address 0.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high system reset
//   spi_busy       in   SPI master transfer in progress
//   spi_in   [7:0] in   byte received by the SPI master (valid when busy falls)
//   mem_in   [7:0] in   framebuffer read data (valid while mem_ready=1)
//   mem_ready      in   framebuffer read-complete pulse
//   dis_reset      out  display RESX pin (low = display held in reset)
//   dc             out  D/CX pin, 0 = command, 1 = data
//   spi_start      out  one-cycle transfer request
//   spi_out  [7:0] out  byte to transmit
//   mem_addr[31:0] out  framebuffer byte address
//   mem_req        out  framebuffer read request
//   display_status[31:0] out  latched RDDST result {b2,b3,b4,b5}
module ili9341_spi_controller #(
  parameter int SYS_CLK_FREQ = 12000000,
  parameter int DISPLAY_X    = 320,
  parameter int DISPLAY_Y    = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_busy,
  input  logic [7:0]  spi_in,
  input  logic [7:0]  mem_in,
  input  logic        mem_ready,
  output logic        dis_reset,
  output logic        dc,
  output logic        spi_start,
  output logic [7:0]  spi_out,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic [31:0] display_status
);

  localparam int HW_RESET_HOLD    = (SYS_CLK_FREQ / 100000 > 4) ? SYS_CLK_FREQ / 100000 : 4;
  localparam int HW_RESET_RELEASE = (SYS_CLK_FREQ / 200 > 4)    ? SYS_CLK_FREQ / 200    : 4;
  localparam int SW_RESET_WAIT    = (SYS_CLK_FREQ / 200 > 4)    ? SYS_CLK_FREQ / 200    : 4;
  localparam int SLPOUT_WAIT      = (SYS_CLK_FREQ / 8 > 4)      ? SYS_CLK_FREQ / 8      : 4;
  localparam int SCREEN_BUF_SIZE  = DISPLAY_X * DISPLAY_Y * 2;

  localparam int TMAX_A = (HW_RESET_HOLD > HW_RESET_RELEASE) ? HW_RESET_HOLD : HW_RESET_RELEASE;
  localparam int TMAX_B = (SW_RESET_WAIT > SLPOUT_WAIT) ? SW_RESET_WAIT : SLPOUT_WAIT;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] HOLD_T    = TW'(HW_RESET_HOLD);
  localparam logic [TW-1:0] RELEASE_T = TW'(HW_RESET_RELEASE);
  localparam logic [TW-1:0] SWRST_T   = TW'(SW_RESET_WAIT);
  localparam logic [TW-1:0] SLPOUT_T  = TW'(SLPOUT_WAIT);
  localparam logic [TW-1:0] TMAX_T    = TW'(TMAX);

  localparam logic [15:0] X16       = 16'(DISPLAY_X);
  localparam logic [15:0] Y16       = 16'(DISPLAY_Y);
  localparam logic [31:0] LAST_ADDR = 32'(SCREEN_BUF_SIZE - 1);

  // Positions in the fixed command/data script; 24 marks the pixel stream.
  localparam logic [4:0] IDX_SWRESET = 5'd0;
  localparam logic [4:0] IDX_SLPOUT  = 5'd1;
  localparam logic [4:0] IDX_RD_B2   = 5'd9;
  localparam logic [4:0] IDX_RD_B4   = 5'd11;
  localparam logic [4:0] IDX_RD_B5   = 5'd12;
  localparam logic [4:0] IDX_RAMWR   = 5'd23;
  localparam logic [4:0] IDX_STREAM  = 5'd24;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_FETCH   = 3'd5
  } state_t;

  // Script ROM: returns {dc, byte} for each scripted transfer.
  function automatic logic [8:0] seq_rom(input logic [4:0] idx);
    logic [8:0] r;
    case (idx)
      5'd0:    r = {1'b0, 8'h01};
      5'd1:    r = {1'b0, 8'h11};
      5'd2:    r = {1'b0, 8'h36};
      5'd3:    r = {1'b1, 8'h28};
      5'd4:    r = {1'b0, 8'h3A};
      5'd5:    r = {1'b1, 8'h55};
      5'd6:    r = {1'b0, 8'h29};
      5'd7:    r = {1'b0, 8'h09};
      5'd13:   r = {1'b0, 8'h2A};
      5'd16:   r = {1'b1, X16[15:8]};
      5'd17:   r = {1'b1, X16[7:0]};
      5'd18:   r = {1'b0, 8'h2B};
      5'd21:   r = {1'b1, Y16[15:8]};
      5'd22:   r = {1'b1, Y16[7:0]};
      5'd23:   r = {1'b0, 8'h2C};
      // Status read clocks (8..12) and window start bytes send data 0x00.
      default: r = {1'b1, 8'h00};
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [4:0]    seq_q, seq_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] need_q, need_d;
  logic          dis_reset_q, dis_reset_d;
  logic          dc_q, dc_d;
  logic          spi_start_q, spi_start_d;
  logic [7:0]    spi_out_q, spi_out_d;
  logic [31:0]   addr_q, addr_d;
  logic          mem_req_q, mem_req_d;
  logic [7:0]    pix_q, pix_d;
  logic [23:0]   status_sh_q, status_sh_d;
  logic [31:0]   display_status_q, display_status_d;

  // Next-state and output computation for the sequencer and byte transfer.
  always_comb begin
    state_d          = state_q;
    seq_d            = seq_q;
    need_d           = need_q;
    dis_reset_d      = dis_reset_q;
    dc_d             = dc_q;
    spi_start_d      = 1'b0;
    spi_out_d        = spi_out_q;
    addr_d           = addr_q;
    mem_req_d        = mem_req_q;
    pix_d            = pix_q;
    status_sh_d      = status_sh_q;
    display_status_d = display_status_q;
    // Free-running saturating timer; cleared when a delay interval begins.
    timer_d          = (timer_q == TMAX_T) ? timer_q : timer_q + TW'(1);

    case (state_q)
      ST_HOLD: begin
        dis_reset_d = 1'b0;
        if (timer_q == HOLD_T) begin
          // RESX rises here; the release wait is measured from this edge.
          dis_reset_d = 1'b1;
          timer_d     = '0;
          need_d      = RELEASE_T;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_LOAD: begin
        // Pending delay must elapse and the SPI master must be idle.
        if (!spi_busy && (timer_q >= need_q)) begin
          if (seq_q == IDX_STREAM) begin
            {dc_d, spi_out_d} = {1'b1, pix_q};
          end else begin
            {dc_d, spi_out_d} = seq_rom(seq_q);
          end
          state_d = ST_START;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_START: begin
        spi_start_d = 1'b1;
        timer_d     = '0;
        if (seq_q == IDX_SWRESET) begin
          need_d = SWRST_T;
        end else if (seq_q == IDX_SLPOUT) begin
          need_d = SLPOUT_T;
        end else begin
          need_d = '0;
        end
        state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        if (spi_busy) begin
          state_d = ST_WAIT_LO;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end

      ST_WAIT_LO: begin
        if (!spi_busy) begin
          // Status bytes 2..4 shift in; byte 5 completes the latched word.
          if ((seq_q >= IDX_RD_B2) && (seq_q <= IDX_RD_B4)) begin
            status_sh_d = {status_sh_q[15:0], spi_in};
          end else if (seq_q == IDX_RD_B5) begin
            display_status_d = {status_sh_q, spi_in};
          end else begin
            status_sh_d = status_sh_q;
          end

          if (seq_q == IDX_STREAM) begin
            if (addr_q == LAST_ADDR) begin
              addr_d  = 32'd0;
              seq_d   = IDX_RAMWR;
              state_d = ST_LOAD;
            end else begin
              addr_d  = addr_q + 32'd1;
              state_d = ST_FETCH;
            end
          end else if (seq_q == IDX_RAMWR) begin
            addr_d  = 32'd0;
            seq_d   = IDX_STREAM;
            state_d = ST_FETCH;
          end else begin
            seq_d   = seq_q + 5'd1;
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_WAIT_LO;
        end
      end

      ST_FETCH: begin
        // Only a ready pulse seen while the request is up is accepted.
        if (mem_req_q && mem_ready) begin
          pix_d     = mem_in;
          mem_req_d = 1'b0;
          state_d   = ST_LOAD;
        end else begin
          mem_req_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // State and output registers; reset restarts the whole bring-up sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_HOLD;
      seq_q            <= 5'd0;
      timer_q          <= '0;
      need_q           <= '0;
      dis_reset_q      <= 1'b1;
      dc_q             <= 1'b0;
      spi_start_q      <= 1'b0;
      spi_out_q        <= 8'h00;
      addr_q           <= 32'd0;
      mem_req_q        <= 1'b0;
      pix_q            <= 8'h00;
      status_sh_q      <= 24'd0;
      display_status_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      seq_q            <= seq_d;
      timer_q          <= timer_d;
      need_q           <= need_d;
      dis_reset_q      <= dis_reset_d;
      dc_q             <= dc_d;
      spi_start_q      <= spi_start_d;
      spi_out_q        <= spi_out_d;
      addr_q           <= addr_d;
      mem_req_q        <= mem_req_d;
      pix_q            <= pix_d;
      status_sh_q      <= status_sh_d;
      display_status_q <= display_status_d;
    end
  end

  assign dis_reset      = dis_reset_q;
  assign dc             = dc_q;
  assign spi_start      = spi_start_q;
  assign spi_out        = spi_out_q;
  assign mem_addr       = addr_q;
  assign mem_req        = mem_req_q;
  assign display_status = display_status_q;

endmodule

// File: tb/tb_ili9341_spi_controller.sv
// Directed bench for ili9341_spi_controller with X=3, Y=4, SYS_CLK_FREQ=1
// (every delay timer is 4 cycles). Includes an SPI master mock and a
// framebuffer mock with a fixed 6-byte RGB565 pattern.
module tb_ili9341_spi_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_in = 8'h00;
  logic [7:0]  mem_in = 8'h00;
  logic        mem_ready = 1'b0;
  logic        dis_reset;
  logic        dc;
  logic        spi_start;
  logic [7:0]  spi_out;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] display_status;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ili9341_spi_controller #(
    .SYS_CLK_FREQ(1),
    .DISPLAY_X(3),
    .DISPLAY_Y(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi_busy(spi_busy),
    .spi_in(spi_in),
    .mem_in(mem_in),
    .mem_ready(mem_ready),
    .dis_reset(dis_reset),
    .dc(dc),
    .spi_start(spi_start),
    .spi_out(spi_out),
    .mem_addr(mem_addr),
    .mem_req(mem_req),
    .display_status(display_status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI master mock: busy rises the edge after spi_start, falls 4 edges later.
  int busy_cnt = 0;
  int xfer_cnt = 0;
  int cur_k = 0;
  bit cnt_mode = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_busy <= 1'b0;
      busy_cnt <= 0;
      xfer_cnt <= 0;
      cur_k    <= 0;
    end else if (spi_start) begin
      spi_busy <= 1'b1;
      busy_cnt <= 4;
      cur_k    <= xfer_cnt;
      xfer_cnt <= xfer_cnt + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        spi_busy <= 1'b0;
        spi_in   <= cnt_mode ? 8'(8'hA0 + cur_k) : 8'hAA;
      end
    end
  end

  // Framebuffer mock: one-cycle read latency, pattern indexed by addr % 6.
  logic [7:0] pat [6] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
    end else if (mem_req && !mem_ready) begin
      mem_ready <= 1'b1;
      mem_in    <= pat[int'(mem_addr % 32'd6)];
    end else begin
      mem_ready <= 1'b0;
    end
  end

  // Transfer log and RESX pulse measurement, sampled on the falling edge.
  logic [7:0]  ev_byte [$];
  logic        ev_dc   [$];
  int          ev_cyc  [$];
  logic [31:0] ev_addr [$];
  logic [31:0] ev_stat [$];
  int dis_low_cnt = 0;
  int dis_rise_cyc = -1;
  always @(negedge clk) begin
    if (reset) begin
      ev_byte.delete();
      ev_dc.delete();
      ev_cyc.delete();
      ev_addr.delete();
      ev_stat.delete();
      dis_low_cnt  <= 0;
      dis_rise_cyc <= -1;
    end else begin
      if (dis_reset === 1'b0) dis_low_cnt <= dis_low_cnt + 1;
      else if (dis_low_cnt > 0 && dis_rise_cyc < 0) dis_rise_cyc <= cyc;
      if (spi_start === 1'b1) begin
        ev_byte.push_back(spi_out);
        ev_dc.push_back(dc);
        ev_cyc.push_back(cyc);
        ev_addr.push_back(mem_addr);
        ev_stat.push_back(display_status);
      end
    end
  end

  task automatic wait_events(input int n, input int budget, input string nm);
    int k = 0;
    while (ev_byte.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (ev_byte.size() < n) begin
      $display("FAIL %s timeout: got %0d transfers, need %0d", nm, ev_byte.size(), n);
      errors++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dis_reset, dc, spi_start, spi_out, mem_req} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      $display("FAIL reset_ctrl got dis=%b dc=%b start=%b out=%h req=%b exp 1 0 0 00 0",
               dis_reset, dc, spi_start, spi_out, mem_req);
      errors++;
    end
    checks++;
    if (mem_addr !== 32'd0 || display_status !== 32'd0) begin
      $display("FAIL reset_data got addr=%h status=%h exp 0 0", mem_addr, display_status);
      errors++;
    end
  endtask

  task automatic test_hw_reset;
    @(negedge clk);
    reset = 1'b0;
    wait_events(1, 200, "hw_reset");
    checks++;
    if (dis_low_cnt !== 4) begin
      $display("FAIL hw_reset_low got %0d cycles exp 4", dis_low_cnt);
      errors++;
    end
    checks++;
    if (!(ev_cyc[0] - dis_rise_cyc > 4)) begin
      $display("FAIL hw_release_gap got %0d exp >4", ev_cyc[0] - dis_rise_cyc);
      errors++;
    end
    checks++;
    if (ev_byte[0] !== 8'h01 || ev_dc[0] !== 1'b0) begin
      $display("FAIL swreset_byte got %h dc=%b exp 01 dc=0", ev_byte[0], ev_dc[0]);
      errors++;
    end
  endtask

  task automatic test_power_delays;
    wait_events(3, 300, "power_delays");
    checks++;
    if (!(ev_cyc[1] - ev_cyc[0] > 4)) begin
      $display("FAIL swreset_gap got %0d exp >4", ev_cyc[1] - ev_cyc[0]);
      errors++;
    end
    checks++;
    if (ev_byte[1] !== 8'h11 || ev_dc[1] !== 1'b0) begin
      $display("FAIL slpout_byte got %h dc=%b exp 11 dc=0", ev_byte[1], ev_dc[1]);
      errors++;
    end
    checks++;
    if (!(ev_cyc[2] - ev_cyc[1] > 4)) begin
      $display("FAIL slpout_gap got %0d exp >4", ev_cyc[2] - ev_cyc[1]);
      errors++;
    end
  endtask

  task automatic test_init_bytes;
    logic [7:0] exp_b [6] = '{8'h36, 8'h28, 8'h3A, 8'h55, 8'h29, 8'h09};
    logic       exp_d [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    wait_events(8, 400, "init_bytes");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ev_byte[i+2] !== exp_b[i] || ev_dc[i+2] !== exp_d[i]) begin
        $display("FAIL init_%0d got %h dc=%b exp %h dc=%b", i, ev_byte[i+2], ev_dc[i+2], exp_b[i], exp_d[i]);
        errors++;
      end
    end
  endtask

  task automatic test_status_read;
    wait_events(14, 400, "status_read");
    for (int i = 8; i <= 12; i++) begin
      checks++;
      if (ev_byte[i] !== 8'h00 || ev_dc[i] !== 1'b1) begin
        $display("FAIL status_rd_%0d got %h dc=%b exp 00 dc=1", i, ev_byte[i], ev_dc[i]);
        errors++;
      end
    end
    checks++;
    if (ev_stat[12] !== 32'h0) begin
      $display("FAIL status_early got %h exp 00000000", ev_stat[12]);
      errors++;
    end
    checks++;
    if (ev_stat[13] !== 32'hAAAAAAAA) begin
      $display("FAIL status_value got %h exp AAAAAAAA", ev_stat[13]);
      errors++;
    end
  endtask

  task automatic test_window;
    logic [7:0] exp_b [11] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h03,
                               8'h2B, 8'h00, 8'h00, 8'h00, 8'h04, 8'h2C};
    logic       exp_d [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    wait_events(24, 600, "window");
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (ev_byte[i+13] !== exp_b[i] || ev_dc[i+13] !== exp_d[i]) begin
        $display("FAIL window_%0d got %h dc=%b exp %h dc=%b", i, ev_byte[i+13], ev_dc[i+13], exp_b[i], exp_d[i]);
        errors++;
      end
    end
  endtask

  task automatic test_stream;
    wait_events(50, 3000, "stream");
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (ev_dc[24+i] !== 1'b1 || ev_addr[24+i] !== 32'(i) || ev_byte[24+i] !== pat[i % 6]) begin
        $display("FAIL stream_%0d got %h dc=%b addr=%0d exp %h dc=1 addr=%0d",
                 i, ev_byte[24+i], ev_dc[24+i], ev_addr[24+i], pat[i % 6], i);
        errors++;
      end
    end
    checks++;
    if (ev_byte[48] !== 8'h2C || ev_dc[48] !== 1'b0 || ev_addr[48] !== 32'd0) begin
      $display("FAIL frame_wrap_cmd got %h dc=%b addr=%0d exp 2C dc=0 addr=0", ev_byte[48], ev_dc[48], ev_addr[48]);
      errors++;
    end
    checks++;
    if (ev_byte[49] !== 8'hF8 || ev_dc[49] !== 1'b1 || ev_addr[49] !== 32'd0) begin
      $display("FAIL frame_wrap_px got %h dc=%b addr=%0d exp F8 dc=1 addr=0", ev_byte[49], ev_dc[49], ev_addr[49]);
      errors++;
    end
  endtask

  task automatic test_abort_restart;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({dis_reset, dc, spi_start, spi_out, mem_req} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}
        || mem_addr !== 32'd0 || display_status !== 32'd0) begin
      $display("FAIL abort_reset got dis=%b dc=%b start=%b out=%h req=%b addr=%h status=%h exp 1 0 0 00 0 0 0",
               dis_reset, dc, spi_start, spi_out, mem_req, mem_addr, display_status);
      errors++;
    end
    cnt_mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_events(14, 600, "restart");
    checks++;
    if (ev_byte[0] !== 8'h01 || ev_dc[0] !== 1'b0) begin
      $display("FAIL restart_first got %h dc=%b exp 01 dc=0", ev_byte[0], ev_dc[0]);
      errors++;
    end
    // Reads are transfers 8..12; the mock answers A0+index, byte 8 is the dummy.
    checks++;
    if (ev_stat[13] !== 32'hA9AAABAC) begin
      $display("FAIL restart_status got %h exp A9AAABAC", ev_stat[13]);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_hw_reset();
    test_power_delays();
    test_init_bytes();
    test_status_read();
    test_window();
    test_stream();
    test_abort_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
